// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP datapath: default widths, activation
// selection and the saturating narrow used by every requantizing stage.
package mlp_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int S1_NUM_DEF     = 8;
  localparam int SAT_W          = 64;

  typedef enum logic [1:0] {
    ACT_IDENT = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2
  } act_mode_e;

  typedef struct packed {
    logic                    sat;
    logic signed [SAT_W-1:0] value;
  } sat_res_t;

  localparam logic signed [SAT_W-1:0] SAT_ONE = 1;

  // Clip a wide signed value into the signed range of out_w bits.
  function automatic sat_res_t sat_narrow(input logic signed [SAT_W-1:0] x,
                                          input int unsigned out_w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_res_t res;
    hi = (SAT_ONE <<< (out_w - 1)) - SAT_ONE;
    lo = -hi - SAT_ONE;
    res.sat   = 1'b0;
    res.value = x;
    if (x > hi) begin
      res.sat   = 1'b1;
      res.value = hi;
    end else if (x < lo) begin
      res.sat   = 1'b1;
      res.value = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/act_fifo.sv
// Synchronous FIFO whose head word and flags come straight from registers,
// so the consumer side never sees a combinational path from pop.
module act_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [AW:0]      count_next;
  logic             push_ok;
  logic             pop_ok;
  logic [WIDTH-1:0] head_next;

  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_next = rd_ptr + AW'(pop_ok);
  // The new head bypasses memory when it is the word being written this edge.
  assign head_next = (push_ok && (wr_ptr == rd_next)) ? din : mem[rd_next];

  always_comb begin
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      dout   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_next;
      count  <= count_next;
      empty  <= (count_next == '0);
      if (count_next != '0) dout <= head_next;
    end
  end

endmodule

// File: rtl/neuron_activation.sv
// Post-accumulation neuron stage: bias add, activation, rounding requantize
// with saturation, then a small output FIFO with a drop/overflow flag.
module neuron_activation
  import mlp_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int S1_NUM     = S1_NUM_DEF,
  parameter  int SHIFT      = 4,
  parameter  int ACT_MODE   = 1,
  parameter  int FIFO_DEPTH = 4,
  localparam int ACC_WIDTH  = 2*DATA_WIDTH + S1_NUM - 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [ACC_WIDTH-1:0]  acc_in,
  input  logic                         acc_valid,
  input  logic signed [DATA_WIDTH-1:0] bias,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         sat_flag,
  output logic                         overflow
);

  localparam int        S1W   = ACC_WIDTH + 2;
  localparam int        CW    = $clog2(FIFO_DEPTH) + 1;
  localparam act_mode_e MODE  = act_mode_e'(ACT_MODE[1:0]);
  localparam logic signed [S1W:0] ROUND = (S1W+1)'((2**SHIFT) / 2);

  logic                    s1_valid;
  logic signed [S1W-1:0]   s1_sum;
  logic signed [S1W-1:0]   act_val;
  logic signed [S1W:0]     rnd_sum;
  logic signed [S1W:0]     rnd_shift;
  logic signed [SAT_W-1:0] r_wide;
  sat_res_t                narrowed;
  logic                    s2_valid;
  logic                    s2_sat;
  logic [DATA_WIDTH-1:0]   s2_data;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CW-1:0]           fifo_count;
  logic                    pop_fire;

  // Bias is aligned to the accumulator's fractional point before the add.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= acc_valid;
      if (acc_valid) s1_sum <= S1W'(acc_in) + (S1W'(bias) <<< SHIFT);
    end
  end

  always_comb begin
    act_val = s1_sum;
    case (MODE)
      ACT_RELU:  if (s1_sum[S1W-1]) act_val = '0;
      ACT_LEAKY: if (s1_sum[S1W-1]) act_val = s1_sum >>> 3;
      default:   act_val = s1_sum;
    endcase
  end

  assign rnd_sum   = (S1W+1)'(act_val) + ROUND;
  assign rnd_shift = rnd_sum >>> SHIFT;
  assign r_wide    = SAT_W'(rnd_shift);
  assign narrowed  = sat_narrow(r_wide, DATA_WIDTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_sat   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= DATA_WIDTH'(narrowed.value);
        s2_sat  <= narrowed.sat;
      end
    end
  end

  assign pop_fire  = !fifo_empty && out_ready;
  assign out_valid = (fifo_count != '0);

  act_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (s2_valid),
    .din   (s2_data),
    .pop   (pop_fire),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A full FIFO still takes a result when the head leaves on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sat_flag <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sat_flag <= s2_valid && s2_sat && (!fifo_full || pop_fire);
      overflow <= overflow | (s2_valid && fifo_full && !pop_fire);
    end
  end

endmodule

// File: tb/tb_neuron_activation.sv
// Drives identity, ReLU and leaky instances in parallel and compares them
// against an arithmetic reference with a queue-based FIFO/pipeline model.
module tb_neuron_activation;

  localparam int DW  = 8;
  localparam int S1N = 8;
  localparam int AW  = 2*DW + S1N - 1;
  localparam int SH  = 4;
  localparam int DEP = 4;

  logic                 clk       = 1'b0;
  logic                 reset     = 1'b1;
  logic                 acc_valid = 1'b0;
  logic                 out_ready = 1'b1;
  logic signed [AW-1:0] acc_in    = '0;
  logic signed [DW-1:0] bias      = '0;

  logic [2:0][DW-1:0] od;
  logic [2:0]         ov;
  logic [2:0]         sf;
  logic [2:0]         of;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 3; m++) begin : g_dut
    neuron_activation #(
      .DATA_WIDTH (DW),
      .S1_NUM     (S1N),
      .SHIFT      (SH),
      .ACT_MODE   (m),
      .FIFO_DEPTH (DEP)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .acc_in    (acc_in),
      .acc_valid (acc_valid),
      .bias      (bias),
      .out_data  (od[m]),
      .out_valid (ov[m]),
      .out_ready (out_ready),
      .sat_flag  (sf[m]),
      .overflow  (of[m])
    );
  end

  typedef struct packed {
    logic [2:0]         sat;
    logic [2:0][DW-1:0] val;
  } res_t;

  typedef struct packed {
    logic signed [31:0] acc;
    logic signed [7:0]  b;
    logic [2:0][7:0]    expv;
    logic [2:0]         exps;
  } vec_t;

  res_t       pend_q[$];
  int         pend_due[$];
  res_t       fifo_q[$];
  int         cyc       = 0;
  bit         exp_ovf   = 1'b0;
  logic [2:0] exp_sat   = '0;
  bit         zero_flag = 1'b1;
  int         tests     = 0;
  int         fails     = 0;
  vec_t       tbl[7];

  function automatic longint floor_div(longint a, longint d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  // Reference arithmetic: exact integers, floor division, explicit clipping.
  function automatic logic [DW:0] ref_calc(longint acc, longint b, int mode);
    longint x;
    longint r;
    longint scale;
    scale = longint'(1) << SH;
    x = acc + b * scale;
    if (x < 0) begin
      if (mode == 1) x = 0;
      else if (mode == 2) x = floor_div(x, 8);
    end
    r = floor_div(x + scale / 2, scale);
    if (r > 127) return {1'b1, 8'sd127};
    if (r < -128) return {1'b1, -8'sd128};
    return {1'b0, DW'(r)};
  endfunction

  function automatic res_t ref_all(longint acc, longint b);
    res_t       res;
    logic [DW:0] tmp;
    for (int m = 0; m < 3; m++) begin
      tmp        = ref_calc(acc, b, m);
      res.sat[m] = tmp[DW];
      res.val[m] = tmp[DW-1:0];
    end
    return res;
  endfunction

  task automatic check(string name, longint got, longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock edge of the reference: results land in the FIFO two edges after sampling.
  task automatic model_edge();
    bit   do_pop;
    bit   was_full;
    res_t e;
    if (reset) begin
      pend_q.delete();
      pend_due.delete();
      fifo_q.delete();
      exp_ovf   = 1'b0;
      exp_sat   = '0;
      zero_flag = 1'b1;
    end else begin
      do_pop   = (fifo_q.size() > 0) && out_ready;
      was_full = (fifo_q.size() == DEP);
      exp_sat  = '0;
      if (do_pop) void'(fifo_q.pop_front());
      if (pend_due.size() > 0 && pend_due[0] == cyc) begin
        e = pend_q.pop_front();
        void'(pend_due.pop_front());
        if (was_full && !do_pop) begin
          exp_ovf = 1'b1;
        end else begin
          fifo_q.push_back(e);
          exp_sat   = e.sat;
          zero_flag = 1'b0;
        end
      end
      if (acc_valid) begin
        pend_q.push_back(ref_all(longint'(acc_in), longint'(bias)));
        pend_due.push_back(cyc + 2);
      end
    end
    cyc++;
  endtask

  task automatic check_output();
    res_t h;
    for (int m = 0; m < 3; m++) begin
      check($sformatf("out_valid[m%0d]", m), longint'(ov[m]), longint'(fifo_q.size() > 0));
      check($sformatf("sat_flag[m%0d]", m), longint'(sf[m]), longint'(exp_sat[m]));
      check($sformatf("overflow[m%0d]", m), longint'(of[m]), longint'(exp_ovf));
      if (fifo_q.size() > 0) begin
        h = fifo_q[0];
        check($sformatf("out_data[m%0d]", m), longint'($signed(od[m])),
              longint'($signed(h.val[m])));
      end else if (zero_flag) begin
        check($sformatf("out_data_rst[m%0d]", m), longint'($signed(od[m])), 0);
      end
    end
  endtask

  task automatic apply_stimulus();
    @(posedge clk);
    model_edge();
    #1;
    check_output();
  endtask

  initial begin
    tbl[0] = '{acc: 100,   b: 0,  expv: {8'sd6, 8'sd6, 8'sd6},        exps: 3'b000};
    tbl[1] = '{acc: -50,   b: 0,  expv: {8'sd0, 8'sd0, -8'sd3},       exps: 3'b000};
    tbl[2] = '{acc: 0,     b: 3,  expv: {8'sd3, 8'sd3, 8'sd3},        exps: 3'b000};
    tbl[3] = '{acc: 8,     b: -1, expv: {8'sd0, 8'sd0, 8'sd0},        exps: 3'b000};
    tbl[4] = '{acc: 5000,  b: 0,  expv: {8'sd127, 8'sd127, 8'sd127},  exps: 3'b111};
    tbl[5] = '{acc: -5000, b: 0,  expv: {-8'sd39, 8'sd0, -8'sd128},   exps: 3'b001};
    tbl[6] = '{acc: -160,  b: 0,  expv: {-8'sd1, 8'sd0, -8'sd10},     exps: 3'b000};

    reset = 1'b1;
    apply_stimulus();
    apply_stimulus();
    reset = 1'b0;
    apply_stimulus();

    // Single results with idle gaps: output is visible just after the third edge.
    for (int i = 0; i < 7; i++) begin
      acc_in    = AW'(tbl[i].acc);
      bias      = tbl[i].b;
      acc_valid = 1'b1;
      apply_stimulus();
      acc_valid = 1'b0;
      bias      = '0;
      apply_stimulus();
      apply_stimulus();
      for (int m = 0; m < 3; m++) begin
        check($sformatf("vec%0d_valid[m%0d]", i, m), longint'(ov[m]), 1);
        check($sformatf("vec%0d_data[m%0d]", i, m), longint'($signed(od[m])),
              longint'($signed(tbl[i].expv[m])));
        check($sformatf("vec%0d_sat[m%0d]", i, m), longint'(sf[m]), longint'(tbl[i].exps[m]));
      end
      apply_stimulus();
    end

    // Backpressure: five results into a four-entry FIFO, last one dropped.
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      acc_in    = AW'(16 * i);
      acc_valid = 1'b1;
      apply_stimulus();
    end
    acc_valid = 1'b0;
    for (int i = 0; i < 3; i++) apply_stimulus();
    check("bp_overflow", longint'(of[1]), 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("bp_drain%0d", i), longint'($signed(od[1])), i);
      apply_stimulus();
    end
    check("bp_empty", longint'(ov[1]), 0);
    check("bp_overflow_sticky", longint'(of[1]), 1);

    // Full FIFO with push and pop on the same edge must not overflow.
    reset = 1'b1;
    apply_stimulus();
    reset     = 1'b0;
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      acc_in    = AW'(16 * i);
      acc_valid = 1'b1;
      apply_stimulus();
    end
    acc_valid = 1'b0;
    for (int i = 0; i < 3; i++) apply_stimulus();
    acc_in    = AW'(80);
    acc_valid = 1'b1;
    apply_stimulus();
    acc_valid = 1'b0;
    apply_stimulus();
    out_ready = 1'b1;
    apply_stimulus();
    out_ready = 1'b0;
    check("pp_no_overflow", longint'(of[1]), 0);
    check("pp_new_head", longint'($signed(od[1])), 2);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) apply_stimulus();

    // Reset one edge after sampling: nothing may ever come out.
    acc_in    = AW'(100);
    acc_valid = 1'b1;
    apply_stimulus();
    acc_valid = 1'b0;
    reset     = 1'b1;
    apply_stimulus();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus();
      check($sformatf("midrst_valid%0d", i), longint'(ov[1]), 0);
      check($sformatf("midrst_ovf%0d", i), longint'(of[1]), 0);
    end

    // Randomized traffic with random backpressure and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      acc_valid = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 1) == 0) acc_in = AW'($urandom);
      else acc_in = AW'(int'($urandom_range(0, 6000)) - 3000);
      bias      = DW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      apply_stimulus();
    end
    reset     = 1'b0;
    acc_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) apply_stimulus();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/neuron_activation.md
# neuron_activation

Post-accumulation stage of each MLP neuron. It consumes the wide signed dot-product that the MAC unit emits once per S1_NUM inputs, then:
- adds the neuron bias,
- applies the activation function,
- requantizes back to DATA_WIDTH with rounding and saturation.

Results are buffered in a small FIFO behind a valid/ready handshake. The MAC has no backpressure, so this block must accept every result it is offered, or drop it and flag the drop.

## Interface
Parameters:
- DATA_WIDTH, 8: width of activations, weights, bias and output.
- S1_NUM, 8: inputs per neuron. ACC_WIDTH = 2*DATA_WIDTH+S1_NUM-1 (localparam).
- SHIFT, 4: requantization right shift (fractional bits). Legal range 0..ACC_WIDTH-DATA_WIDTH.
- ACT_MODE, 1: activation select. 0 identity, 1 ReLU, 2 leaky ReLU (negative slope 1/8).
- FIFO_DEPTH, 4: output buffer entries. Power of two, ≥2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  reset, synchronous, active-high; clock clk.
- acc_in  in  ACC_WIDTH  signed MAC result.
- acc_valid  in  1  single-cycle pulse; acc_in valid.
- bias  in  DATA_WIDTH  signed bias, same fixed-point scale as output; sampled with acc_valid.
- out_data  out  DATA_WIDTH  signed activated result (FIFO head).
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready.
- sat_flag  out  1  one-cycle pulse; the result just written to the FIFO was saturated.
- overflow  out  1  sticky; a result was dropped because the FIFO was full. Cleared only by reset.

## Operation
- Reset: pipeline valids, FIFO pointers and count, overflow and sat_flag go to 0. out_valid=0; out_data=0.
- Stage 1 (edge sampling acc_valid=1):
  - s1 = sext(acc_in) + (sext(bias) <<< SHIFT).
  - Width ACC_WIDTH+2; no wrap possible.
- Stage 2: apply activation to s1.
  - ReLU: x<0 → 0.
  - Leaky: x<0 → x>>>3 (arithmetic, floor).
  - Identity: x.
- Requantize:
  - r = (a + 2^(SHIFT-1)) >>> SHIFT, i.e. round half up. With SHIFT=0, r = a.
  - Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - sat_flag is set when clipping occurs.
- FIFO write: stage-2 result is pushed on the next edge.
  - If the FIFO is full and no pop occurs that cycle, the result is discarded, overflow←1, and sat_flag is not asserted.
- Pop: when out_valid && out_ready on an edge, the head advances.
- Simultaneous push and pop:
  - When full, both occur; count is unchanged and there is no overflow.
  - When empty, a pop is impossible because out_valid=0.
- Back-to-back acc_valid on consecutive cycles must be sustained. The pipeline never stalls.
- Reset mid-operation discards all in-flight and buffered results.

## Timing
- acc_valid sampled at edge E0 → stage-1 register at E0 → stage-2 register at E1 → FIFO write at E2 → out_valid=1 in the cycle after E2. Latency is 3 edges, throughput is 1 result/cycle.
- sat_flag is high for exactly the cycle following the write edge E2.
- out_data/out_valid are registered outputs. out_ready has no combinational path to out_valid.
- out_data holds stable while out_valid && !out_ready.

## Structure
- Shared package mlp_pkg:
  - DATA_WIDTH/S1_NUM defaults.
  - act_mode_e enum (ACT_IDENT, ACT_RELU, ACT_LEAKY).
  - Saturating-narrow function sat_narrow(). The output layer reuses it.
- Sub-module act_fifo: parameterized synchronous FIFO with push, pop, full, empty, count.
- The arithmetic pipeline stays in neuron_activation.

## Test plan
All scenarios use defaults (DATA_WIDTH 8, SHIFT 4, ReLU) unless stated; out_ready=1 unless stated.
- Basic ReLU, bias=0: acc_in=100 → out_data=6 after 3 edges. Then acc_in=-50 → 0.
- Bias and rounding: bias=3, acc_in=0 → 3. Then bias=-1, acc_in=8 → 0 (-16+8+8=0 → 0).
- Saturation: acc_in=5000 → 127 with sat_flag pulse. Identity mode, acc_in=-5000 → -128 with sat_flag.
- Leaky: ACT_MODE=2, acc_in=-160, bias=0 → -20 → out_data=-1.
- Backpressure:
  - out_ready=0, five back-to-back results 16,32,48,64,80 → FIFO holds 1,2,3,4; 5th dropped; overflow=1.
  - Raise out_ready → 1,2,3,4 drain in order; overflow stays 1.
  - Additionally, with the FIFO full, a push and pop in the same cycle → no overflow.
- Reset mid-flight: acc_valid at E0, reset at E1 → no output ever appears; out_valid=0, overflow=0.
